// File: rtl/vram_pkg.sv
// vram_pkg: constants and state encoding shared by the VRAM arbiter files.
//   FB_W/FB_H   framebuffer size (half the VGA resolution in each axis)
//   FB_DEPTH    number of framebuffer words
//   ADDR_W      linear RAM address width
//   PIX_W       BGR pixel width
//   ROW_W/COL_W VGA row/column address widths
package vram_pkg;

  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_DEPTH = FB_W * FB_H;
  localparam int ADDR_W   = 17;
  localparam int PIX_W    = 12;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/vram_addr_map.sv
// vram_addr_map: maps a VGA row/column to a framebuffer word address.
//   row_i       VGA row (0..2*FB_H-1 is visible)
//   col_i       VGA column (0..2*FB_W-1 is visible)
//   addr_o      linear address; each framebuffer pixel covers a 2x2 VGA block
//   in_range_o  1 when row_i/col_i fall inside the visible area
module vram_addr_map #(
  parameter int FB_W   = vram_pkg::FB_W,
  parameter int FB_H   = vram_pkg::FB_H,
  parameter int ADDR_W = vram_pkg::ADDR_W
) (
  input  logic [vram_pkg::ROW_W-1:0] row_i,
  input  logic [vram_pkg::COL_W-1:0] col_i,
  output logic [ADDR_W-1:0]          addr_o,
  output logic                       in_range_o
);
  import vram_pkg::*;

  // Dropping the LSB of row and column doubles every pixel in both axes.
  assign addr_o = ADDR_W'(row_i[ROW_W-1:1]) * ADDR_W'(FB_W)
                + ADDR_W'(col_i[COL_W-1:1]);

  assign in_range_o = (int'(row_i) < 2 * FB_H) && (int'(col_i) < 2 * FB_W);

endmodule

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous framebuffer RAM between
// the VGA scan-out, single-pixel writes from game logic and a full-buffer
// clear engine. One RAM access per cycle, priority VGA > write > clear.
//   vga_clk, clrn                 clock, synchronous active-high reset
//   vga_read/vga_row/vga_col      scan-out request; vga_pixel 2 cycles later
//   wr_req/wr_addr/wr_data/wr_ack single-pixel write, ack is combinational
//   clr_req/clr_color             start a clear; clr_busy/clr_done status
//   mem_addr/mem_we/mem_wdata     RAM port; mem_rdata arrives 1 cycle later
//
// state    | meaning
// ST_IDLE  | no clear running, free slots are unused
// ST_CLEAR | free slots write clr colour at the clear pointer
module vram_arbiter #(
  parameter int FB_W   = vram_pkg::FB_W,
  parameter int FB_H   = vram_pkg::FB_H,
  parameter int ADDR_W = vram_pkg::ADDR_W
) (
  input  logic                       vga_clk,
  input  logic                       clrn,
  input  logic                       vga_read,
  input  logic [vram_pkg::ROW_W-1:0] vga_row,
  input  logic [vram_pkg::COL_W-1:0] vga_col,
  output logic [vram_pkg::PIX_W-1:0] vga_pixel,
  input  logic                       wr_req,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [vram_pkg::PIX_W-1:0] wr_data,
  output logic                       wr_ack,
  input  logic                       clr_req,
  input  logic [vram_pkg::PIX_W-1:0] clr_color,
  output logic                       clr_busy,
  output logic                       clr_done,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_we,
  output logic [vram_pkg::PIX_W-1:0] mem_wdata,
  input  logic [vram_pkg::PIX_W-1:0] mem_rdata
);
  import vram_pkg::*;

  localparam int                DEPTH     = FB_W * FB_H;
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] vga_addr;
  logic              vga_in_range;

  vram_addr_map #(
    .FB_W  (FB_W),
    .FB_H  (FB_H),
    .ADDR_W(ADDR_W)
  ) u_addr_map (
    .row_i     (vga_row),
    .col_i     (vga_col),
    .addr_o    (vga_addr),
    .in_range_o(vga_in_range)
  );

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [PIX_W-1:0]  color_q, color_d;
  logic [ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]  wdata_q;
  logic              rd_vld_q;
  logic [PIX_W-1:0]  pix_q;
  logic              rd_go;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    color_d   = color_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    wr_ack    = 1'b0;
    clr_done  = 1'b0;
    rd_go     = 1'b0;

    // An asserted vga_read owns the slot even when off-screen; it then
    // issues no read and the address simply holds.
    if (vga_read) begin
      rd_go = vga_in_range;
      if (vga_in_range) mem_addr = vga_addr;
    end else if (wr_req) begin
      wr_ack = 1'b1;
      if (wr_addr < DEPTH_A) begin
        mem_addr  = wr_addr;
        mem_wdata = wr_data;
        mem_we    = 1'b1;
      end
    end else if (state_q == ST_CLEAR) begin
      mem_addr  = ptr_q;
      mem_wdata = color_q;
      mem_we    = 1'b1;
      ptr_d     = ptr_q + ADDR_W'(1);
      if (ptr_q == LAST_ADDR) begin
        clr_done = 1'b1;
        state_d  = ST_IDLE;
      end
    end

    // Clear requests are only honoured from IDLE; a write granted in the
    // same cycle does not block the start.
    if (state_q == ST_IDLE && clr_req) begin
      state_d = ST_CLEAR;
      ptr_d   = '0;
      color_d = clr_color;
    end

    if (clrn) begin
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      mem_we    = 1'b0;
      wr_ack    = 1'b0;
      clr_done  = 1'b0;
      rd_go     = 1'b0;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (clrn) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      color_q  <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_vld_q <= 1'b0;
      pix_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      color_q  <= color_d;
      addr_q   <= mem_addr;
      wdata_q  <= mem_wdata;
      rd_vld_q <= rd_go;
      pix_q    <= rd_vld_q ? mem_rdata : '0;
    end
  end

  assign vga_pixel = pix_q;
  assign clr_busy  = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  localparam int DEPTH = 76800;

  logic        clk = 1'b0;
  logic        clrn;
  logic        vga_read;
  logic [8:0]  vga_row;
  logic [9:0]  vga_col;
  logic [11:0] vga_pixel;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic        clr_req;
  logic [11:0] clr_color;
  logic        clr_busy;
  logic        clr_done;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;

  always #5 clk = ~clk;

  vram_arbiter dut (
    .vga_clk  (clk),
    .clrn     (clrn),
    .vga_read (vga_read),
    .vga_row  (vga_row),
    .vga_col  (vga_col),
    .vga_pixel(vga_pixel),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_ack   (wr_ack),
    .clr_req  (clr_req),
    .clr_color(clr_color),
    .clr_busy (clr_busy),
    .clr_done (clr_done),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  function automatic logic [11:0] exp_pix(input int a);
    if (a == 322) return 12'hABC;
    return 12'(a * 37 + 11);
  endfunction

  // RAM model: preloaded on the first edge, registered read.
  logic [11:0] ram [0:DEPTH-1];
  bit          loaded;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= exp_pix(i);
      loaded <= 1'b1;
    end else if (int'(mem_addr) < DEPTH) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pixel scoreboard: expectation pushed for each driven cycle, compared
  // two cycles later.
  logic [11:0] sbq [$];

  task automatic half();
    logic [11:0] e;
    @(negedge clk);
    if (clrn) begin
      sbq.delete();
    end else begin
      e = 12'h000;
      if (vga_read && vga_row < 9'd480 && vga_col < 10'd640)
        e = exp_pix(int'(vga_row) / 2 * 320 + int'(vga_col) / 2);
      sbq.push_back(e);
      if (sbq.size() >= 3) chk("pix", vga_pixel, sbq.pop_front());
    end
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    half();
    rise();
  endtask

  int  exp_ptr, n_wr, seq_err, cyc;
  bit  finished, injected, irq_done;
  int  ea;

  initial begin
    clrn = 1'b1; vga_read = 1'b0; vga_row = '0; vga_col = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; clr_req = 1'b0; clr_color = '0;
    rise(); rise();
    half();
    chk("rst_busy", clr_busy, 0);
    chk("rst_done", clr_done, 0);
    chk("rst_ack", wr_ack, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_pix", vga_pixel, 0);
    rise();
    clrn = 1'b0;
    tick();

    // single read, latency 2
    vga_read = 1'b1; vga_row = 9'd2; vga_col = 10'd4;
    half();
    chk("rd_addr", mem_addr, 322);
    chk("rd_we", mem_we, 0);
    rise();
    vga_read = 1'b0;
    half();
    chk("rd_lat1", vga_pixel, 0);
    rise();
    half();
    chk("rd_lat2", vga_pixel, 12'hABC);
    rise();

    // random reads, in and out of range
    for (int i = 0; i < 60; i++) begin
      vga_read = ($urandom_range(0, 3) != 0);
      vga_row  = 9'($urandom_range(0, 511));
      vga_col  = 10'($urandom_range(0, 1023));
      half();
      ea = int'(vga_row) / 2 * 320 + int'(vga_col) / 2;
      if (vga_read && vga_row < 9'd480 && vga_col < 10'd640)
        chk("rnd_addr", mem_addr, ea);
      rise();
    end
    vga_read = 1'b0;
    tick(); tick();

    // write blocked by continuous VGA reads
    vga_read = 1'b1; vga_row = '0; vga_col = '0;
    wr_req = 1'b1; wr_addr = 17'd5; wr_data = 12'h555;
    for (int i = 0; i < 4; i++) begin
      half();
      chk("wr_blk_ack", wr_ack, 0);
      chk("wr_blk_we", mem_we, 0);
      rise();
    end
    vga_read = 1'b0;
    half();
    chk("wr_ack", wr_ack, 1);
    chk("wr_we", mem_we, 1);
    chk("wr_addr", mem_addr, 5);
    chk("wr_data", mem_wdata, 12'h555);
    rise();

    // held request is granted again
    wr_addr = 17'd6; wr_data = 12'h666;
    for (int i = 0; i < 2; i++) begin
      half();
      chk("wr_hold_ack", wr_ack, 1);
      chk("wr_hold_addr", mem_addr, 6);
      rise();
    end
    wr_req = 1'b0;
    half();
    chk("idle_ack", wr_ack, 0);
    chk("idle_we", mem_we, 0);
    chk("idle_addr_hold", mem_addr, 6);
    chk("idle_wdata_hold", mem_wdata, 12'h666);
    rise();

    // out-of-range write
    wr_req = 1'b1; wr_addr = 17'd76800; wr_data = 12'hFFF;
    half();
    chk("oor_wr_ack", wr_ack, 1);
    chk("oor_wr_we", mem_we, 0);
    rise();
    wr_req = 1'b0;
    chk("ram5", ram[5], 12'h555);

    // in-range read followed by off-screen read
    vga_read = 1'b1; vga_row = 9'd2; vga_col = 10'd4;
    tick();
    vga_row = 9'd480; vga_col = 10'd0;
    half();
    chk("oor_rd_addr_hold", mem_addr, 322);
    rise();
    vga_read = 1'b0;
    half();
    chk("oor_prev_pix", vga_pixel, 12'hABC);
    rise();
    half();
    chk("oor_pix", vga_pixel, 0);
    rise();

    // clear started together with a write
    clr_req = 1'b1; clr_color = 12'h0F0;
    wr_req = 1'b1; wr_addr = 17'd7; wr_data = 12'h777;
    half();
    chk("cw_ack", wr_ack, 1);
    chk("cw_addr", mem_addr, 7);
    chk("cw_busy", clr_busy, 0);
    rise();
    clr_req = 1'b0; wr_req = 1'b0; clr_color = 12'h000;

    exp_ptr = 0; n_wr = 0; seq_err = 0; cyc = 0;
    finished = 1'b0; irq_done = 1'b0;
    while (cyc < 80000 && !finished) begin
      injected = 1'b0;
      if (exp_ptr == 100 && !irq_done) begin
        wr_req = 1'b1; wr_addr = 17'd50000; wr_data = 12'h123;
        injected = 1'b1; irq_done = 1'b1;
      end else begin
        wr_req = 1'b0;
      end
      clr_req   = (exp_ptr == 200);
      clr_color = 12'hF00;
      half();
      if (cyc == 0) chk("clr_busy_on", clr_busy, 1);
      if (injected) begin
        chk("clr_irq_ack", wr_ack, 1);
        chk("clr_irq_addr", mem_addr, 50000);
        chk("clr_irq_data", mem_wdata, 12'h123);
        chk("clr_irq_done", clr_done, 0);
      end else begin
        if (!mem_we || int'(mem_addr) != exp_ptr || mem_wdata != 12'h0F0) seq_err++;
        if (clr_done != (exp_ptr == DEPTH - 1)) seq_err++;
        if (clr_done) finished = 1'b1;
        exp_ptr++;
        n_wr++;
      end
      rise();
      cyc++;
    end
    wr_req = 1'b0; clr_req = 1'b0;
    chk("clr_finished", finished, 1);
    chk("clr_writes", n_wr, DEPTH);
    chk("clr_seq_err", seq_err, 0);
    half();
    chk("clr_busy_off", clr_busy, 0);
    chk("clr_done_off", clr_done, 0);
    chk("clr_we_off", mem_we, 0);
    rise();
    chk("ram0", ram[0], 12'h0F0);
    chk("ram100", ram[100], 12'h0F0);
    chk("ram50000", ram[50000], 12'h0F0);
    chk("ram_last", ram[DEPTH-1], 12'h0F0);

    // clear aborted by reset at pointer 5000
    clr_req = 1'b1; clr_color = 12'h00F;
    tick();
    clr_req = 1'b0;
    exp_ptr = 0; seq_err = 0; cyc = 0;
    while (exp_ptr < 5000 && cyc < 6000) begin
      half();
      if (mem_we && int'(mem_addr) == exp_ptr && mem_wdata == 12'h00F) exp_ptr++;
      else seq_err++;
      rise();
      cyc++;
    end
    chk("abort_reach", exp_ptr, 5000);
    chk("abort_seq_err", seq_err, 0);
    clrn = 1'b1;
    half();
    chk("abort_rst_we", mem_we, 0);
    chk("abort_rst_done", clr_done, 0);
    rise();
    clrn = 1'b0;
    half();
    chk("abort_busy", clr_busy, 0);
    chk("abort_we", mem_we, 0);
    chk("abort_done", clr_done, 0);
    rise();
    tick();
    chk("abort_ram4999", ram[4999], 12'h00F);
    chk("abort_ram5000", ram[5000], 12'h0F0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameters: FB_W=320, pixels per framebuffer row; FB_H=240, framebuffer rows; ADDR_W=17, linear address width.
REQ-002 vga_clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 clrn  in  1  reset, synchronous and active-high.
REQ-004 vga_read  in  1  VGA controller pixel request (visible area).
REQ-005 vga_row  in  9  VGA row address, 0..479.
REQ-006 vga_col  in  10  VGA column address, 0..639.
REQ-007 vga_pixel  out  12  BGR pixel to the VGA controller d_in_BGR input.
REQ-008 wr_req  in  1  game-logic single-pixel write request; held until wr_ack.
REQ-009 wr_addr  in  17  linear write address.
REQ-010 wr_data  in  12  write pixel, BGR.
REQ-011 wr_ack  out  1  one-cycle pulse when the write slot is granted.
REQ-012 clr_req  in  1  one-cycle pulse that starts a full-buffer clear.
REQ-013 clr_color  in  12  clear pixel, sampled with clr_req.
REQ-014 clr_busy  out  1  clear in progress.
REQ-015 clr_done  out  1  one-cycle pulse on the last clear write.
REQ-016 mem_addr  out  17  single-port synchronous RAM address.
REQ-017 mem_we  out  1  RAM write enable.
REQ-018 mem_wdata  out  12  RAM write data.
REQ-019 mem_rdata  in  12  RAM read data, valid one cycle after the address.

Function
REQ-020 Exactly one RAM access per cycle; slot priority: VGA read > single write > clear write.
REQ-021 VGA address = (vga_row>>1)*FB_W + (vga_col>>1), giving 2x2 pixel doubling.
REQ-022 vga_read=1 in cycle N: mem_addr = VGA address, mem_we=0; vga_pixel = mem_rdata registered at the end of N+1, visible from N+2 (latency 2).
REQ-023 vga_read=0, or vga_row>=480, or vga_col>=640, in cycle N: vga_pixel = 12'h000 from N+2, and no RAM read is issued.
REQ-024 Write slot: vga_read=0 and wr_req=1 -> mem_addr=wr_addr, mem_wdata=wr_data, mem_we=1, wr_ack=1, all in the same cycle (combinational grant, registered state).
REQ-025 wr_addr>=76800: wr_ack still pulses; mem_we=0.
REQ-026 After wr_ack the requester drops or changes wr_req; if wr_req stays high, it is granted again on the next free slot.
REQ-027 FSM states: IDLE, CLEAR. IDLE->CLEAR on clr_req: latch clr_color, clear pointer=0, clr_busy=1 from the next cycle.
REQ-028 CLEAR: each slot not taken by a VGA read or a single write issues mem_addr=pointer, mem_wdata=latched colour, mem_we=1, then pointer+1.
REQ-029 Pointer=76799 written -> clr_done=1 that cycle; next state IDLE; clr_busy=0 the following cycle.
REQ-030 clr_req while in CLEAR is ignored; the latched colour is unchanged.
REQ-031 Simultaneous clr_req and wr_req in IDLE with vga_read=0: the write is granted, and the clear still starts.
REQ-032 No RAM access in a cycle: mem_we=0 and mem_addr holds its last value.

Reset
REQ-033 clrn=1 at an edge: state=IDLE, pointer=0, clr_busy=0, clr_done=0, wr_ack=0, mem_we=0, mem_addr=0, mem_wdata=0, vga_pixel=12'h000, read pipeline valid bits cleared.
REQ-034 Reset mid-clear aborts the clear with no clr_done; pixels already written stay written.

Structure
REQ-035 Shared package vram_pkg holds FB_W, FB_H, FB_DEPTH=76800, ADDR_W, the pixel width 12 and the state encoding.
REQ-036 One combinational sub-module, vram_addr_map, takes row/col to linear address plus an in-range flag; used for the VGA path.

Verification
REQ-037 vga_read=1, row=2, col=4, mem model holds 12'hABC at address 322 -> mem_addr=322 in N, vga_pixel=12'hABC at N+2.
REQ-038 vga_read=1 continuously with wr_req=1, wr_addr=5 -> no wr_ack; when vga_read drops, wr_ack=1 and mem_we=1 at addr 5 in that cycle.
REQ-039 clr_req with clr_color=12'h0F0 and vga_read=0 -> clr_busy from the next cycle; 76800 writes to addresses 0..76799, each with data 12'h0F0; clr_done on address 76799.
REQ-040 Clear running, wr_req pulses at pointer=100 -> write granted in that cycle; clear pointer stays at 100 and resumes the next cycle; clear total is still 76800 writes.
REQ-041 clrn=1 asserted at pointer=5000 -> clr_busy=0 the next cycle, no clr_done, mem_we=0.
REQ-042 wr_addr=76800 -> wr_ack=1 with mem_we=0; vga_read=1 with row=480 -> vga_pixel=0 two cycles later.
